int_fp_convert: RTL and testbench
=================================

Name: int_fp_convert

Overview:
- Two-stage pipelined converter between int8 and fp16. It runs in the opposite direction to the int/fp16 adder datapath: it produces fp16 operands from int8 data and returns fp16 results to int8.
- mode=1: int8 -> fp16. mode=0: fp16 -> int8, truncating toward zero and saturating.
- Placed beside the int_fp_add/MAC datapath for format changes at the array boundary. Accepts one conversion per cycle.

Parameters:
- NAN_INT, 8'h00, int8 value returned for an fp16 NaN input.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid this cycle.
- mode  input  1  1 = int8->fp16, 0 = fp16->int8; sampled with in_valid.
- a  input  16  operand. mode=1: a[7:0] is two's-complement int8 and a[15:8] is ignored. mode=0: a is fp16.
- out_valid  output  1  result valid.
- c  output  16  result. mode=1: fp16. mode=0: int8 sign-extended to 16 bits.
- sat  output  1  fp16->int8 result was clamped (overflow, inf or NaN). Always 0 for mode=1.
- inexact  output  1  fp16->int8 discarded nonzero fraction bits. Always 0 for mode=1.

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: out_valid=0, c=16'h0000, sat=0, inexact=0; all pipeline registers cleared.
- Reset mid-operation: in-flight conversions are discarded; no out_valid pulse follows reset release.
- Latency: operand with in_valid at edge N gives out_valid=1 with the result after edge N+2.
  - Throughput is 1/cycle.
  - mode may change every cycle and travels with its operand.
  - No backpressure.
- Bubbles: stage data registers load only when their valid bit is set. c, sat and inexact hold their last value while out_valid=0.
- Stage 1 (register at edge N+1):
  - Classify the operand.
  - mode=1: take the absolute value m (9 bits, so -128 gives 128) and the leading-one position p (0..8).
  - mode=0: compute sign, exponent e, 11-bit significand {1,mant} and shift amount e-15.
- Stage 2 (register at edge N+2): shift, pack, set flags.
- int8 -> fp16 (always exact):
  - 0 -> 16'h0000.
  - Otherwise sign = a[7], exp = 15+p, mant = (m << (10-p))[9:0].
  - Examples: 5 -> 16'h4500, -1 -> 16'hBC00, 127 -> 16'h57F0, -128 -> 16'hD800.
- fp16 -> int8:
  - e=31, mant≠0 (NaN): result NAN_INT, sat=1.
  - e=31, mant=0 (inf): result 127 or -128 by sign, sat=1.
  - e<15 (|x|<1, including zero and subnormals): result 0, inexact=1 unless a[14:0]=0. -0 gives 0.
  - 15≤e≤21: mag = {1,mant} >> (25-e), negated if sign=1. inexact=1 when any shifted-out bit is 1.
  - e=22 with sign=1 and mant=0: exactly -128, no flags.
  - Any other e≥22: clamp to 127 or -128 by sign, sat=1, inexact=0.
  - Output c = {{8{r[7]}}, r}.

Decomposition:
- Shared package int_fp_pkg holds:
  - FP16_BIAS=15, FP16_EXP_W=5, FP16_MAN_W=10, FP16_EXP_MAX=31.
  - INT8_MAX=127, INT8_MIN=-128.
  - Mode encodings MODE_FP=1, MODE_INT=0, shared with int_fp_add.
- One sub-module, lod9: combinational 9-bit leading-one detector returning the position and a zero flag, used in stage 1.
- The rest stays in int_fp_convert.

Test Plan:
- Reset, then int8 stream 5, -1, 127, -128, 0 with mode=1 on consecutive cycles -> out_valid pulses 2 cycles later, back to back: 4500, BC00, 57F0, D800, 0000, flags 0.
- mode=0 with 4500 (5.0) -> 0005; C640 (-6.25) -> FFFA with inexact=1; 3800 (0.5) -> 0000 with inexact=1; 8000 -> 0000, no flags.
- mode=0 with 5A00 (192) -> 007F, sat=1; D800 (-128) -> FF80, no flags; D810 (-130) -> FF80, sat=1.
- mode=0 with 7C00 -> 007F, sat=1; FC00 -> FF80, sat=1; 7E00 -> 0000 (NAN_INT), sat=1.
- Alternate mode every cycle with in_valid gaps (e.g. 1,0,1,1) -> each result matches its own mode, out_valid mirrors the input pattern delayed 2 cycles, and c holds during gaps.
- Assert rst_n low while 2 conversions are in flight -> outputs 0 immediately, no out_valid after release; the next input converts correctly.

Source files
------------

// File: rtl/int_fp_pkg.sv
// Shared int8/fp16 format constants, mode codes and pipeline bundles.
// Used by int_fp_convert and the int_fp_add datapath.
package int_fp_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam logic [FP16_EXP_W-1:0] FP16_BIAS    = 5'd15;
    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'd31;

    localparam logic [7:0] INT8_MAX = 8'h7F;
    localparam logic [7:0] INT8_MIN = 8'h80;

    localparam logic MODE_FP  = 1'b1;
    localparam logic MODE_INT = 1'b0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SHIFT,
        CLS_NAN,
        CLS_INF,
        CLS_MIN,
        CLS_SAT
    } cls_t;

    typedef struct packed {
        logic        mode;
        logic [15:0] a;
    } in_t;

    typedef struct packed {
        logic        mode;
        logic        sign;
        logic        nz;
        cls_t        cls;
        logic [10:0] sig;
        logic [3:0]  sh;
    } s1_t;

    function automatic logic [7:0] neg8(input logic [7:0] v);
        return 8'd0 - v;
    endfunction

endpackage

// File: rtl/int_fp_convert_lod9.sv
// Combinational 9-bit leading-one detector.
// pos is the index of the highest set bit; zero flags an all-zero input.
module lod9 (
    input  logic [8:0] v,
    output logic [3:0] pos,
    output logic       zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) pos = 4'(i);
        end
    end

    assign zero = ~|v;

endmodule

// File: rtl/int_fp_convert.sv
// Pipelined int8 <-> fp16 converter, one conversion per cycle.
// Input register, classify stage, then shift/pack into the output register.
module int_fp_convert
    import int_fp_pkg::*;
#(
    parameter logic [7:0] NAN_INT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mode,
    input  logic [15:0] a,
    output logic        out_valid,
    output logic [15:0] c,
    output logic        sat,
    output logic        inexact
);

    logic v0;
    in_t  s0;
    logic v1;
    s1_t  s1;
    s1_t  s1_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            s0 <= '0;
        end else begin
            v0 <= in_valid;
            if (in_valid) s0 <= '{mode: mode, a: a};
        end
    end

    logic [8:0] mag9;
    logic [3:0] lod_pos;
    logic       lod_zero;

    assign mag9 = s0.a[7] ? (9'd0 - {1'b1, s0.a[7:0]})
                          : {1'b0, s0.a[7:0]};

    lod9 u_lod (
        .v    (mag9),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    logic [4:0] fexp;
    logic [9:0] fman;
    logic [4:0] ediff;

    assign fexp  = s0.a[14:10];
    assign fman  = s0.a[9:0];
    assign ediff = fexp - FP16_BIAS;

    always_comb begin
        s1_nxt      = '0;
        s1_nxt.mode = s0.mode;
        if (s0.mode == MODE_FP) begin
            s1_nxt.sign = s0.a[7];
            s1_nxt.sig  = {2'b00, mag9};
            s1_nxt.sh   = lod_pos;
            s1_nxt.cls  = lod_zero ? CLS_ZERO : CLS_SHIFT;
        end else begin
            s1_nxt.sign = s0.a[15];
            s1_nxt.sig  = {1'b1, fman};
            s1_nxt.nz   = |s0.a[14:0];
            unique case (1'b1)
                (fexp == FP16_EXP_MAX && fman != '0):
                    s1_nxt.cls = CLS_NAN;
                (fexp == FP16_EXP_MAX && fman == '0):
                    s1_nxt.cls = CLS_INF;
                (fexp < FP16_BIAS):
                    s1_nxt.cls = CLS_ZERO;
                (fexp >= FP16_BIAS && fexp <= 5'd21): begin
                    s1_nxt.cls = CLS_SHIFT;
                    s1_nxt.sh  = ediff[3:0];
                end
                (fexp == 5'd22 && s0.a[15] && fman == '0):
                    s1_nxt.cls = CLS_MIN;
                default:
                    s1_nxt.cls = CLS_SAT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            v1 <= v0;
            if (v0) s1 <= s1_nxt;
        end
    end

    // One right/left shift amount serves both directions: 10 - p or 10 - (e-15).
    logic [3:0]  sh_amt;
    logic [18:0] itmp;
    logic [4:0]  iexp;
    logic [10:0] fmag;
    logic [10:0] lost_mask;
    logic        lost;
    logic [7:0]  r8;
    logic [15:0] res_c;
    logic        res_sat;
    logic        res_inx;

    assign sh_amt    = 4'd10 - s1.sh;
    assign itmp      = {10'd0, s1.sig[8:0]} << sh_amt;
    assign iexp      = FP16_BIAS + {1'b0, s1.sh};
    assign fmag      = s1.sig >> sh_amt;
    assign lost_mask = ~(11'h7FF << sh_amt);
    assign lost      = |(s1.sig & lost_mask);

    always_comb begin
        res_c   = '0;
        res_sat = 1'b0;
        res_inx = 1'b0;
        r8      = '0;
        if (s1.mode == MODE_FP) begin
            if (s1.cls != CLS_ZERO) begin
                res_c = {s1.sign, iexp, itmp[9:0]};
            end
        end else begin
            unique case (s1.cls)
                CLS_NAN: begin
                    r8      = NAN_INT;
                    res_sat = 1'b1;
                end
                CLS_INF: begin
                    r8      = s1.sign ? INT8_MIN : INT8_MAX;
                    res_sat = 1'b1;
                end
                CLS_ZERO: begin
                    res_inx = s1.nz;
                end
                CLS_SHIFT: begin
                    r8      = s1.sign ? neg8(fmag[7:0]) : fmag[7:0];
                    res_inx = lost;
                end
                CLS_MIN: begin
                    r8 = INT8_MIN;
                end
                default: begin
                    r8      = s1.sign ? INT8_MIN : INT8_MAX;
                    res_sat = 1'b1;
                end
            endcase
            res_c = {{8{r8[7]}}, r8};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            sat       <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                c       <= res_c;
                sat     <= res_sat;
                inexact <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_int_fp_convert.sv
// Scoreboard bench for int_fp_convert: directed vectors plus a
// randomized mixed-mode stream checked against a real-valued model.
module tb_int_fp_convert;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0;
    logic        out_valid;
    logic [15:0] c;
    logic        sat;
    logic        inexact;

    int_fp_convert #(.NAN_INT(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .a         (a),
        .out_valid (out_valid),
        .c         (c),
        .sat       (sat),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic        sat;
        logic        inx;
        int          cyc;
        logic [15:0] a;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    logic [15:0] last_c = '0;
    logic        last_sat = 1'b0;
    logic        last_inx = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", {15'd0, out_valid}, 16'h0000);
            last_c   = '0;
            last_sat = 1'b0;
            last_inx = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {15'd0, out_valid}, 16'h0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("c a=%h", e.a), c, e.c);
                chk($sformatf("sat a=%h", e.a), {15'd0, sat}, {15'd0, e.sat});
                chk($sformatf("inexact a=%h", e.a), {15'd0, inexact},
                    {15'd0, e.inx});
                chk($sformatf("latency a=%h", e.a), cyc[15:0], e.cyc[15:0]);
            end
            last_c   = c;
            last_sat = sat;
            last_inx = inexact;
        end else begin
            chk("hold_c", c, last_c);
            chk("hold_flags", {14'd0, sat, inexact}, {14'd0, last_sat, last_inx});
        end
    end

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
        else for (int i = 0; i < -k; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic logic [15:0] int2fp(input logic [7:0] x);
        int mag;
        int p;
        int frac;
        logic [4:0] ex;
        logic [9:0] mn;
        if (x == 8'h00) return 16'h0000;
        mag = x[7] ? 256 - int'(x) : int'(x);
        p = 0;
        while ((mag >> p) > 1) p++;
        frac = (mag - (1 << p)) << (10 - p);
        ex = 5'(15 + p);
        mn = 10'(frac);
        return {x[7], ex, mn};
    endfunction

    task automatic fp2int(input logic [15:0] x, output logic [15:0] r,
                          output logic s, output logic i);
        int  e;
        int  m;
        real v;
        int  t;
        logic [7:0] r8;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        s = 1'b0;
        i = 1'b0;
        if (e == 31 && m != 0) begin
            r8 = 8'h00;
            s  = 1'b1;
        end else if (e == 31) begin
            r8 = x[15] ? 8'h80 : 8'h7F;
            s  = 1'b1;
        end else begin
            v = (e == 0) ? real'(m) * pow2(-24)
                         : real'(1024 + m) * pow2(e - 25);
            if (x[15]) v = -v;
            if (v >= 128.0) begin
                r8 = 8'h7F;
                s  = 1'b1;
            end else if (v < -128.0) begin
                r8 = 8'h80;
                s  = 1'b1;
            end else begin
                t  = $rtoi(v);
                r8 = 8'(t);
                i  = (real'(t) != v);
            end
        end
        r = {{8{r8[7]}}, r8};
    endtask

    task automatic send(input logic m, input logic [15:0] av,
                        input logic [15:0] ec, input logic es,
                        input logic ei);
        exp_t e;
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        e.c   = ec;
        e.sat = es;
        e.inx = ei;
        e.cyc = cyc + 3;
        e.a   = av;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input logic m, input logic [15:0] av);
        logic [15:0] r;
        logic s;
        logic i;
        if (m) begin
            r = int2fp(av[7:0]);
            s = 1'b0;
            i = 1'b0;
        end else begin
            fp2int(av, r, s, i);
        end
        send(m, av, r, s, i);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = $urandom();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("reset_c", c, 16'h0000);
        chk("reset_flags", {13'd0, out_valid, sat, inexact}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(1'b1, 16'h0005, 16'h4500, 1'b0, 1'b0);
        send(1'b1, 16'hAAFF, 16'hBC00, 1'b0, 1'b0);
        send(1'b1, 16'h007F, 16'h57F0, 1'b0, 1'b0);
        send(1'b1, 16'h0080, 16'hD800, 1'b0, 1'b0);
        send(1'b1, 16'h5500, 16'h0000, 1'b0, 1'b0);
        idle();

        send(1'b0, 16'h4500, 16'h0005, 1'b0, 1'b0);
        send(1'b0, 16'hC640, 16'hFFFA, 1'b0, 1'b1);
        send(1'b0, 16'h3800, 16'h0000, 1'b0, 1'b1);
        send(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0);
        send(1'b0, 16'h5A00, 16'h007F, 1'b1, 1'b0);
        send(1'b0, 16'hD800, 16'hFF80, 1'b0, 1'b0);
        send(1'b0, 16'hD810, 16'hFF80, 1'b1, 1'b0);
        send(1'b0, 16'h7C00, 16'h007F, 1'b1, 1'b0);
        send(1'b0, 16'hFC00, 16'hFF80, 1'b1, 1'b0);
        send(1'b0, 16'h7E00, 16'h0000, 1'b1, 1'b0);
        send(1'b0, 16'h57F0, 16'h007F, 1'b0, 1'b0);
        send(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1);
        idle();

        send(1'b1, 16'h0003, 16'h4200, 1'b0, 1'b0);
        idle();
        send(1'b0, 16'h4500, 16'h0005, 1'b0, 1'b0);
        send(1'b1, 16'h00FE, 16'hC000, 1'b0, 1'b0);
        idle();
        idle();
        idle();

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_model(1'($urandom_range(0, 1)), 16'($urandom()));
        end
        for (int k = 0; k < 4; k++) idle();

        in_valid = 1'b1;
        mode     = 1'b1;
        a        = 16'h0011;
        @(posedge clk);
        #1;
        mode = 1'b0;
        a    = 16'h4A00;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_c", c, 16'h0000);
        chk("midrst_flags", {13'd0, out_valid, sat, inexact}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) idle();
        send(1'b0, 16'h4A00, 16'h000C, 1'b0, 1'b0);
        send(1'b1, 16'h0011, 16'h4C40, 1'b0, 1'b0);
        idle();

        for (int k = 0; k < 10 && sb.size() != 0; k++) idle();
        chk("drain", 16'(sb.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
